// File: rtl/serial_add_seq.sv
// Bit-serial add sequencer driving an external single-bit full-adder slice, LSB first.
// Optional subtract mode (A-B via ~B and carry-in 1) when SERIAL_ADD_SUB_EN is defined.
module serial_add_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             ready,
    output logic             busy,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out,
    output logic             done
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum_sh;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sum_out;
    logic             r_cout_out;
    logic [WIDTH-1:0] w_b_load;
    logic             w_carry_load;
    logic             w_last;

`ifdef SERIAL_ADD_SUB_EN
    assign w_b_load     = sub ? ~b_in : b_in;
    assign w_carry_load = sub ? 1'b1 : cin_in;
`else
    assign w_b_load     = b_in;
    assign w_carry_load = cin_in;
`endif

    assign w_last = (r_cnt == LAST_BIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_SHIFT;
            S_SHIFT: if (w_last) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a_sh     <= '0;
            r_b_sh     <= '0;
            r_sum_sh   <= '0;
            r_carry    <= 1'b0;
            r_cnt      <= '0;
            r_sum_out  <= '0;
            r_cout_out <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sh   <= a_in;
                        r_b_sh   <= w_b_load;
                        r_carry  <= w_carry_load;
                        r_cnt    <= '0;
                        r_sum_sh <= '0;
                    end
                end
                S_SHIFT: begin
                    // Sum bits enter at the MSB so the first (LSB) bit lands at bit 0 after WIDTH shifts.
                    r_sum_sh <= {fa_sum, r_sum_sh[WIDTH-1:1]};
                    r_carry  <= fa_cout;
                    r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_sum_out  <= {fa_sum, r_sum_sh[WIDTH-1:1]};
                        r_cout_out <= fa_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ready  = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        fa_a   = 1'b0;
        fa_b   = 1'b0;
        fa_cin = 1'b0;
        case (r_state)
            S_IDLE: ready = 1'b1;
            S_SHIFT: begin
                busy   = 1'b1;
                fa_a   = r_a_sh[0];
                fa_b   = r_b_sh[0];
                fa_cin = r_carry;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign sum_out  = r_sum_out;
    assign cout_out = r_cout_out;

endmodule

// File: tb/tb_serial_add_seq.sv
// Self-checking bench for serial_add_seq (WIDTH=8) with a behavioural full-adder slice attached.
module tb_serial_add_seq;

    localparam int unsigned W = 8;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin_in;
    logic         sub_v;
    logic         ready;
    logic         busy;
    logic         fa_a;
    logic         fa_b;
    logic         fa_cin;
    logic         fa_sum;
    logic         fa_cout;
    logic [W-1:0] sum_out;
    logic         cout_out;
    logic         done;

    int checks = 0;
    int errors = 0;

    serial_add_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .cin_in   (cin_in),
`ifdef SERIAL_ADD_SUB_EN
        .sub      (sub_v),
`endif
        .ready    (ready),
        .busy     (busy),
        .fa_a     (fa_a),
        .fa_b     (fa_b),
        .fa_cin   (fa_cin),
        .fa_sum   (fa_sum),
        .fa_cout  (fa_cout),
        .sum_out  (sum_out),
        .cout_out (cout_out),
        .done     (done)
    );

    // External full-adder slice.
    assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = (fa_a & fa_b) | (fa_cin & (fa_a ^ fa_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: whole-word arithmetic, W+1 bits wide.
    function automatic logic [W:0] model_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic cin, input logic sb);
        int unsigned bb;
        int unsigned cc;
        bb = sb ? ((~int'(b)) & ((1 << W) - 1)) : int'(b);
        cc = sb ? 1 : int'(cin);
        return (W+1)'(int'(a) + bb + cc);
    endfunction

    // Carry entering each bit position, from partial sums of the low bits.
    function automatic logic [W-1:0] model_carries(input logic [W-1:0] a, input logic [W-1:0] b,
                                                   input logic cin, input logic sb);
        logic [W-1:0] r;
        int unsigned bb;
        int unsigned cc;
        int unsigned msk;
        bb = sb ? ((~int'(b)) & ((1 << W) - 1)) : int'(b);
        cc = sb ? 1 : int'(cin);
        r = '0;
        for (int i = 0; i < int'(W); i++) begin
            msk = (1 << i) - 1;
            r[i] = (((int'(a) & msk) + (bb & msk) + cc) >> i) != 0;
        end
        return r;
    endfunction

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic sb, input int inject,
                         output logic [W-1:0] got_sum, output logic got_cout,
                         output int lat, output int ndone, output logic rdy_after,
                         output logic [W-1:0] trace);
        @(negedge clk);
        a_in = a; b_in = b; cin_in = cin; sub_v = sb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1; ndone = 0; rdy_after = 1'b0; trace = '0;
        for (int k = 1; k <= int'(W) + 4; k++) begin
            if (k - 1 < int'(W)) trace[k-1] = fa_cin;
            if (k - 1 == inject) begin
                a_in = 8'hAA; b_in = 8'h55; start = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (lat > 0 && k == lat + 1) rdy_after = ready;
            if (done) begin
                ndone++;
                if (lat < 0) lat = k;
            end
        end
        got_sum = sum_out;
        got_cout = cout_out;
    endtask

    logic [W-1:0] gs;
    logic         gc;
    int           lat;
    int           nd;
    logic         ra;
    logic [W-1:0] tr;
    logic [W:0]   ref_r;
    bit           saw_done;

    initial begin
        reset_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; cin_in = 1'b0; sub_v = 1'b0;

        vecs.push_back('{8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0});
        vecs.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0});
        vecs.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1});
        vecs.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0});
`ifdef SERIAL_ADD_SUB_EN
        vecs.push_back('{8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1});
        vecs.push_back('{8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0});
`endif

        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", 64'(ready), 64'd1);
        check("reset_busy",  64'(busy), 64'd0);
        check("reset_done",  64'(done), 64'd0);
        check("reset_sum",   64'(sum_out), 64'd0);
        check("reset_cout",  64'(cout_out), 64'd0);
        check("reset_fa",    64'({fa_a, fa_b, fa_cin}), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, -1, gs, gc, lat, nd, ra, tr);
            check($sformatf("vec%0d_sum", i), 64'(gs), 64'(vecs[i].exp_sum));
            check($sformatf("vec%0d_cout", i), 64'(gc), 64'(vecs[i].exp_cout));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(W));
            check($sformatf("vec%0d_done_count", i), 64'(nd), 64'd1);
            check($sformatf("vec%0d_ready_after", i), 64'(ra), 64'd1);
            check($sformatf("vec%0d_fa_cin_trace", i), 64'(tr),
                  64'(model_carries(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub)));
        end
        check("idle_fa", 64'({fa_a, fa_b, fa_cin}), 64'd0);

        // Start during SHIFT must be ignored, and operand changes have no effect.
        do_op(8'h0F, 8'h01, 1'b0, 1'b0, 3, gs, gc, lat, nd, ra, tr);
        check("busy_start_sum", 64'(gs), 64'h10);
        check("busy_start_done_count", 64'(nd), 64'd1);
        check("busy_start_ready", 64'(ready), 64'd1);

        // Reset in the middle of SHIFT.
        @(negedge clk);
        a_in = 8'h33; b_in = 8'h44; cin_in = 1'b0; sub_v = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid_busy_before", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        check("mid_reset_ready", 64'(ready), 64'd1);
        check("mid_reset_busy",  64'(busy), 64'd0);
        check("mid_reset_sum",   64'(sum_out), 64'd0);
        check("mid_reset_fa",    64'({fa_a, fa_b, fa_cin}), 64'd0);
        saw_done = 1'b0;
        for (int k = 0; k < int'(W) + 2; k++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
            if (k == 1) reset_n = 1'b1;
        end
        check("mid_reset_no_done", 64'(saw_done), 64'd0);
        do_op(8'h01, 8'h02, 1'b0, 1'b0, -1, gs, gc, lat, nd, ra, tr);
        check("post_reset_sum", 64'(gs), 64'h03);
        check("post_reset_cout", 64'(gc), 64'd0);

        // Randomized operands against the whole-word model.
        for (int n = 0; n < 25; n++) begin
            logic [W-1:0] ra_v;
            logic [W-1:0] rb_v;
            logic         rc_v;
            logic         rs_v;
            ra_v = W'($urandom);
            rb_v = W'($urandom);
            rc_v = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
            rs_v = 1'($urandom);
`else
            rs_v = 1'b0;
`endif
            ref_r = model_add(ra_v, rb_v, rc_v, rs_v);
            do_op(ra_v, rb_v, rc_v, rs_v, -1, gs, gc, lat, nd, ra, tr);
            check($sformatf("rand%0d_result", n), 64'({gc, gs}), 64'(ref_r));
            check($sformatf("rand%0d_done", n), 64'({lat[7:0], nd[7:0]}), 64'({8'(W), 8'd1}));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
